// File: rtl/hamming_encoder_tx.sv
// Hamming(15,11) encoder with optional single-bit error injection, feeding an
// LSB-first framed serial transmitter through a one-word holding register.
module hamming_encoder_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    input  logic        inj_en,
    input  logic [3:0]  inj_pos,
    output logic        tx_bit,
    output logic        tx_valid,
    output logic        tx_start,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} state_t;

    localparam logic [3:0] LAST_BIT = 4'd14;
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit         GAP_NONE = (GAP_CYCLES == 0);

    // Bit placement matches the corrector: parity at indices 0,1,3,7.
    function automatic logic [14:0] hamming_encode(input logic [10:0] d);
        logic [14:0] c;
        c        = 15'd0;
        c[2]     = d[0];
        c[4]     = d[1];
        c[5]     = d[2];
        c[6]     = d[3];
        c[14:8]  = d[10:4];
        c[0]     = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
        c[1]     = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
        c[3]     = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        c[7]     = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        return c;
    endfunction

    function automatic logic [14:0] inject_error(input logic [14:0] cw, input logic en,
                                                 input logic [3:0] pos);
        logic [14:0] r;
        if (en && (pos != 4'd0)) begin
            r = cw ^ (15'd1 << (pos - 4'd1));
        end else begin
            r = cw;
        end
        return r;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        hold_full_r, hold_full_nxt_s;
    logic [14:0] hold_data_r, hold_data_nxt_s;
    logic [14:0] shift_r, shift_nxt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [3:0]  gap_cnt_r, gap_cnt_nxt_s;
    logic        load_s, accept_s;
    logic        in_ready_r, tx_bit_r, tx_valid_r, tx_start_r, busy_r;
    logic        tx_bit_nxt_s, tx_valid_nxt_s, tx_start_nxt_s, busy_nxt_s;

    assign accept_s = in_valid && in_ready_r;

    // State, shifter, counters and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_full_r <= 1'b0;
            hold_data_r <= 15'd0;
            shift_r     <= 15'd0;
            bit_cnt_r   <= 4'd0;
            gap_cnt_r   <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            hold_data_r <= hold_data_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
        end
    end

    // Next-state logic; a frame end or gap end with a word waiting reloads without a bubble.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == LAST_BIT) begin
                    if (GAP_NONE) begin
                        if (hold_full_r) begin
                            load_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s   = ST_GAP;
                        gap_cnt_nxt_s = 4'd0;
                    end
                end else begin
                    shift_nxt_s   = {1'b0, shift_r[14:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    if (hold_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (load_s) begin
            state_nxt_s   = ST_SHIFT;
            shift_nxt_s   = hold_data_r;
            bit_cnt_nxt_s = 4'd0;
        end else begin
            bit_cnt_nxt_s = bit_cnt_nxt_s;
        end
    end

    // Holding register: a word accepted on a load edge replaces the one leaving.
    always_comb begin
        hold_full_nxt_s = hold_full_r;
        hold_data_nxt_s = hold_data_r;
        if (accept_s) begin
            hold_full_nxt_s = 1'b1;
            hold_data_nxt_s = inject_error(hamming_encode(in_data), inj_en, inj_pos);
        end else if (load_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end
    end

    // Output decode from next state so every output leaves a flop.
    always_comb begin
        tx_valid_nxt_s = (state_nxt_s == ST_SHIFT);
        tx_bit_nxt_s   = tx_valid_nxt_s & shift_nxt_s[0];
        tx_start_nxt_s = tx_valid_nxt_s && (bit_cnt_nxt_s == 4'd0);
        busy_nxt_s     = hold_full_nxt_s || (state_nxt_s != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            tx_bit_r   <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            in_ready_r <= !hold_full_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign in_ready = in_ready_r;
    assign tx_bit   = tx_bit_r;
    assign tx_valid = tx_valid_r;
    assign tx_start = tx_start_r;
    assign busy     = busy_r;

endmodule

// File: doc/hamming_encoder_tx.md
Name: hamming_encoder_tx

Overview:
Sequential Hamming(15,11) encoder and serial transmitter. It is the transmit-side counterpart of the team's single-error-correcting Hamming(15,11) corrector.
- Accepts 11-bit data words over a valid/ready handshake.
- Builds 15-bit codewords with the same bit placement the corrector expects.
- Optionally injects a single-bit error for link testing.
- Shifts each codeword out LSB-first on a framed 1-bit serial line.

Parameters:
GAP_CYCLES, 0, idle cycles inserted between consecutive frames (0..15).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/inj_* valid this cycle
in_ready  output  1  block can accept a word this cycle
in_data  input  11  data word d[10:0]
inj_en  input  1  enable error injection for this word
inj_pos  input  4  1-based codeword position to flip (1..15; 0 = none)
tx_bit  output  1  serial codeword bit
tx_valid  output  1  tx_bit is a codeword bit this cycle
tx_start  output  1  high with bit 0 (first bit) of each frame
busy  output  1  holding register full or frame in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0:
  - in_ready=0, tx_bit=0, tx_valid=0, tx_start=0, busy=0.
  - Holding register, shifter, bit counter and gap counter are cleared.
  - in_ready=1 from the first clk edge after rst_n releases.
- Reset mid-frame: the frame is abandoned immediately (tx_valid drops asynchronously) and the held word is discarded.
- Codeword mapping, using index i = position-1:
  - Data: d0→c2, d1→c4, d2→c5, d3→c6, d4..d10→c8..c14.
  - c0 = c2^c4^c6^c8^c10^c12^c14.
  - c1 = c2^c5^c6^c9^c10^c13^c14.
  - c3 = c4^c5^c6^c11^c12^c13^c14.
  - c7 = c8^c9^c10^c11^c12^c13^c14.
- Injection:
  - inj_en and inj_pos are sampled with the accepted word.
  - If inj_en=1 and inj_pos≠0, bit c[inj_pos-1] is inverted after parity generation.
  - If inj_pos=0 or inj_en=0, the codeword is unmodified.
- Handshake:
  - in_ready = !hold_full (registered state, no combinational path from in_valid).
  - A transfer occurs on an edge where in_valid && in_ready; the encoded codeword is stored in the holding register and hold_full is set.
  - in_data must be ignored when in_valid=0.
- Shifter FSM states:
  - IDLE: tx_valid=0.
    - If hold_full, load the shifter on the next edge, clear hold_full, go to SHIFT with bit count 0.
  - SHIFT: tx_valid=1, tx_bit = shifter bit 0, tx_start=1 only at count 0.
    - Each edge shifts right and increments the count.
    - After bit 14 (count=14 edge): go to GAP if GAP_CYCLES>0, else IDLE. If hold_full at that edge and GAP_CYCLES=0, load directly so the next frame's bit 0 follows bit 14 with no bubble.
  - GAP: tx_valid=0 for exactly GAP_CYCLES cycles, then behave as IDLE.
- Latency: word accepted at edge E0 with shifter idle → tx_start/bit 0 valid in the cycle after edge E1; bit 14 in the cycle after edge E15.
- Simultaneous events:
  - If the shifter loads from hold on the same edge a new word is accepted, hold_full stays 1 with the new word; the new word must not be lost or overwrite the loading one.
  - Throughput with GAP_CYCLES=0: one word per 15 cycles sustained.
- busy = hold_full || state≠IDLE.

Test Plan:
- Reset then in_data=11'h000, no injection → 15 tx_valid cycles, tx_start only on the first, serial codeword 15'h0000; in_ready=1 again the cycle after accept.
- in_data=11'h7FF → codeword 15'h7FFF; in_data=11'h001 → 15'h0007 (LSB-first bits 1,1,1,0…0).
- in_data=11'h000, inj_en=1, inj_pos=5 → 15'h0010. Feeding that codeword to the team's corrector yields 11'h000. inj_pos=0 → 15'h0000.
- Three words back-to-back, in_valid held high, GAP_CYCLES=0:
  - in_ready drops after the 2nd accept.
  - 45 contiguous tx_valid cycles, tx_start at cycles 0, 15 and 30, no word lost.
  - GAP_CYCLES=3 → exactly 3 tx_valid=0 cycles between frames.
- Assert rst_n=0 at frame bit 7 with one word held → tx_valid/busy drop immediately. After release, no stale frame is sent; a new word is transmitted correctly.
- Random 11-bit words with random inj_pos (0..15): encoder output through the corrector must always return the original data.
